// File: rtl/ldpc_decode_sequencer.sv
// Frame sequencer for the LDPC decoder: intrinsic load, alternating CNU/VNU sweeps,
// syndrome-based early termination and hard-decision read-out.
module ldpc_decode_sequencer #(
    parameter int unsigned L          = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned K          = 6,
    parameter int unsigned ITER_WIDTH = 5,
    parameter int unsigned MAX_ITER   = 16,
    parameter int unsigned CNU_LAT    = 4,
    parameter int unsigned READ_LAT   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3*K-1:0]        syn_in,
    input  logic                  syn_valid,
    output logic                  en,
    output logic                  load_en,
    output logic                  cnu_phase,
    output logic                  vnu_phase,
    output logic                  sweep_en,
    output logic [ADDR_WIDTH-1:0] load_add,
    output logic [ADDR_WIDTH-1:0] sweep_add,
    output logic [ADDR_WIDTH-1:0] read_add,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  converged,
    output logic [ITER_WIDTH-1:0] iter_count
);

    localparam int unsigned SYN_W   = 3 * K;
    localparam int unsigned DRAIN_W = (CNU_LAT > 1) ? $clog2(CNU_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CNU,
        S_VNU,
        S_READ,
        S_DONE
    } state_t;

    state_t                state_q;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] load_add_q;
    logic [ADDR_WIDTH-1:0] sweep_add_q;
    logic [ADDR_WIDTH-1:0] read_add_q;
    logic                  draining_q;
    logic [DRAIN_W-1:0]    drain_cnt_q;
    logic [ITER_WIDTH-1:0] iter_q;
    logic                  conv_q;
    logic [SYN_W-1:0]      syn_acc_q;
    logic [READ_LAT-1:0]   ov_pipe_q;
    logic                  read_en;

    logic                  in_sweep_state;
    logic                  sweep_last;
    logic                  drain_last;
    logic                  load_last;
    logic                  read_last;
    logic [SYN_W-1:0]      syn_cur;
    logic [SYN_W-1:0]      syn_final;
    logic [ITER_WIDTH-1:0] iter_inc;
    logic                  cnu_exit;
    logic                  frame_start;

    assign in_sweep_state = (state_q == S_CNU) || (state_q == S_VNU);
    assign sweep_last     = in_sweep_state && !draining_q && (sweep_add_q == ADDR_WIDTH'(L - 1));
    assign drain_last     = in_sweep_state && draining_q && (drain_cnt_q == DRAIN_W'(CNU_LAT - 1));
    assign load_last      = load_en && (load_add_q == ADDR_WIDTH'(L - 1));
    assign read_last      = (state_q == S_READ) && (read_add_q == ADDR_WIDTH'(L - 1));
    // The last drain cycle's parity bits count towards the exit decision.
    assign syn_cur        = syn_valid ? syn_in : '0;
    assign syn_final      = syn_acc_q | syn_cur;
    assign iter_inc       = iter_q + 1'b1;
    assign cnu_exit       = (state_q == S_CNU) && drain_last && (syn_final == '0) && (iter_q != '0);
    assign frame_start    = (state_q == S_IDLE) && start;

    // State register
    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin : next_state
        state_nxt = state_q;
        case (state_q)
            S_IDLE: if (start) state_nxt = S_LOAD;
            S_LOAD: if (load_last) state_nxt = S_CNU;
            S_CNU: begin
                if (drain_last) state_nxt = cnu_exit ? S_READ : S_VNU;
            end
            S_VNU: begin
                if (drain_last) state_nxt = (iter_inc == ITER_WIDTH'(MAX_ITER)) ? S_READ : S_CNU;
            end
            S_READ: if (read_last) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from state and counter registers
    always_comb begin : outputs
        in_ready   = 1'b0;
        load_en    = 1'b0;
        en         = 1'b0;
        cnu_phase  = 1'b0;
        vnu_phase  = 1'b0;
        sweep_en   = 1'b0;
        read_en    = 1'b0;
        done       = 1'b0;
        busy       = (state_q != S_IDLE);
        case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                load_en  = in_valid;
                en       = 1'b1;
            end
            S_CNU: begin
                en        = 1'b1;
                cnu_phase = 1'b1;
                sweep_en  = !draining_q;
            end
            S_VNU: begin
                en        = 1'b1;
                vnu_phase = 1'b1;
                sweep_en  = !draining_q;
            end
            S_READ: begin
                en      = 1'b1;
                read_en = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
        load_add   = load_add_q;
        sweep_add  = sweep_add_q;
        read_add   = read_add_q;
        out_valid  = ov_pipe_q[READ_LAT-1];
        converged  = conv_q;
        iter_count = iter_q;
    end

    // Address counters, drain timer, syndrome accumulator and read-valid pipe
    always_ff @(posedge clk) begin : datapath
        if (rst) begin
            load_add_q  <= '0;
            sweep_add_q <= '0;
            read_add_q  <= '0;
            draining_q  <= 1'b0;
            drain_cnt_q <= '0;
            iter_q      <= '0;
            conv_q      <= 1'b0;
            syn_acc_q   <= '0;
            ov_pipe_q   <= '0;
        end else begin
            ov_pipe_q[0] <= read_en;
            for (int i = 1; i < int'(READ_LAT); i++) begin
                ov_pipe_q[i] <= ov_pipe_q[i-1];
            end

            if (frame_start) begin
                load_add_q <= '0;
            end else if (load_en) begin
                load_add_q <= load_add_q + 1'b1;
            end

            // Sweep address wraps to 0 on its own as the drain begins.
            if (in_sweep_state) begin
                if (!draining_q) begin
                    sweep_add_q <= sweep_add_q + 1'b1;
                    if (sweep_last) begin
                        draining_q  <= 1'b1;
                        drain_cnt_q <= '0;
                    end
                end else if (drain_last) begin
                    draining_q  <= 1'b0;
                    drain_cnt_q <= '0;
                end else begin
                    drain_cnt_q <= drain_cnt_q + 1'b1;
                end
            end

            if (state_nxt == S_CNU && state_q != S_CNU) begin
                syn_acc_q <= '0;
            end else if (state_q == S_CNU) begin
                syn_acc_q <= syn_final;
            end

            if (frame_start) begin
                iter_q <= '0;
            end else if (state_q == S_VNU && drain_last) begin
                iter_q <= iter_inc;
            end

            if (frame_start) begin
                conv_q <= 1'b0;
            end else if (cnu_exit) begin
                conv_q <= 1'b1;
            end

            if (read_en) begin
                read_add_q <= read_add_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ldpc_decode_sequencer.sv
// Bench for ldpc_decode_sequencer: directed test-plan frames plus randomized frames,
// compared cycle by cycle against a frame-schedule reference model.
module tb_ldpc_decode_sequencer;

    localparam int unsigned L    = 4;
    localparam int unsigned AW   = 2;
    localparam int unsigned K    = 2;
    localparam int unsigned IW   = 3;
    localparam int unsigned MI   = 3;
    localparam int unsigned CL   = 2;
    localparam int unsigned RL   = 2;
    localparam int unsigned SW   = 3 * K;
    localparam int          MAXC = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [SW-1:0] syn_in;
    logic          syn_valid;
    logic          en;
    logic          load_en;
    logic          cnu_phase;
    logic          vnu_phase;
    logic          sweep_en;
    logic [AW-1:0] load_add;
    logic [AW-1:0] sweep_add;
    logic [AW-1:0] read_add;
    logic          out_valid;
    logic          busy;
    logic          done;
    logic          converged;
    logic [IW-1:0] iter_count;

    always #5 clk = ~clk;

    ldpc_decode_sequencer #(
        .L(L), .ADDR_WIDTH(AW), .K(K), .ITER_WIDTH(IW),
        .MAX_ITER(MI), .CNU_LAT(CL), .READ_LAT(RL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .syn_in(syn_in), .syn_valid(syn_valid), .en(en), .load_en(load_en),
        .cnu_phase(cnu_phase), .vnu_phase(vnu_phase), .sweep_en(sweep_en),
        .load_add(load_add), .sweep_add(sweep_add), .read_add(read_add),
        .out_valid(out_valid), .busy(busy), .done(done), .converged(converged),
        .iter_count(iter_count)
    );

    typedef struct packed {
        logic          en;
        logic          in_ready;
        logic          load_en;
        logic          cnu;
        logic          vnu;
        logic          sweep_en;
        logic          busy;
        logic          done;
        logic          out_valid;
        logic          converged;
        logic [AW-1:0] load_add;
        logic [AW-1:0] sweep_add;
        logic [AW-1:0] read_add;
        logic [IW-1:0] iter;
    } obs_t;

    obs_t          exp_q [MAXC];
    bit            iv    [MAXC];
    bit            sv    [MAXC];
    bit            st    [MAXC];
    bit            rd    [MAXC];
    logic [SW-1:0] sy    [MAXC];

    int            nchk = 0;
    int            nerr = 0;
    int            frame_len;
    int            exp_done;
    logic          prev_conv;
    logic [IW-1:0] prev_iter;
    int            obs_done, obs_ov, obs_cnu, obs_vnu, obs_conv, obs_iter;

    function automatic obs_t sample();
        obs_t o;
        o           = '0;
        o.en        = en;
        o.in_ready  = in_ready;
        o.load_en   = load_en;
        o.cnu       = cnu_phase;
        o.vnu       = vnu_phase;
        o.sweep_en  = sweep_en;
        o.busy      = busy;
        o.done      = done;
        o.out_valid = out_valid;
        o.converged = converged;
        o.load_add  = load_add;
        o.sweep_add = sweep_add;
        o.read_add  = read_add;
        o.iter      = iter_count;
        return o;
    endfunction

    task automatic check(input string tag, input obs_t got, input obs_t want);
        nchk++;
        assert (got === want) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        nchk++;
        assert (got === want) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < MAXC; i++) begin
            iv[i] = 1'b1;
            sv[i] = 1'b1;
            sy[i] = '1;
            st[i] = 1'b0;
        end
        st[0] = 1'b1;
    endtask

    // Reference schedule: lays out load, CNU/VNU blocks, read and done for one frame.
    task automatic build_frame();
        int            c;
        int            acc;
        int            it;
        logic          cv;
        logic [SW-1:0] orv;
        for (int i = 0; i < MAXC; i++) begin
            exp_q[i] = '0;
            rd[i]    = 1'b0;
        end
        exp_q[0].converged = prev_conv;
        exp_q[0].iter      = prev_iter;
        c   = 1;
        acc = 0;
        while (acc < int'(L)) begin
            exp_q[c].en       = 1'b1;
            exp_q[c].busy     = 1'b1;
            exp_q[c].in_ready = 1'b1;
            exp_q[c].load_en  = iv[c];
            exp_q[c].load_add = AW'(acc);
            if (iv[c]) acc++;
            c++;
        end
        it = 0;
        cv = 1'b0;
        while (1'b1) begin
            orv = '0;
            for (int j = 0; j < int'(L + CL); j++) begin
                exp_q[c+j].en        = 1'b1;
                exp_q[c+j].busy      = 1'b1;
                exp_q[c+j].cnu       = 1'b1;
                exp_q[c+j].sweep_en  = (j < int'(L));
                exp_q[c+j].sweep_add = (j < int'(L)) ? AW'(j) : '0;
                exp_q[c+j].iter      = IW'(it);
                if (sv[c+j]) orv = orv | sy[c+j];
            end
            c += int'(L + CL);
            if (orv == '0 && it >= 1) begin
                cv = 1'b1;
                break;
            end
            for (int j = 0; j < int'(L + CL); j++) begin
                exp_q[c+j].en        = 1'b1;
                exp_q[c+j].busy      = 1'b1;
                exp_q[c+j].vnu       = 1'b1;
                exp_q[c+j].sweep_en  = (j < int'(L));
                exp_q[c+j].sweep_add = (j < int'(L)) ? AW'(j) : '0;
                exp_q[c+j].iter      = IW'(it);
            end
            c += int'(L + CL);
            it++;
            if (it == int'(MI)) break;
        end
        for (int j = 0; j < int'(L); j++) begin
            exp_q[c+j].en        = 1'b1;
            exp_q[c+j].busy      = 1'b1;
            exp_q[c+j].read_add  = AW'(j);
            exp_q[c+j].iter      = IW'(it);
            exp_q[c+j].converged = cv;
            rd[c+j]              = 1'b1;
        end
        c += int'(L);
        exp_q[c].busy      = 1'b1;
        exp_q[c].done      = 1'b1;
        exp_q[c].iter      = IW'(it);
        exp_q[c].converged = cv;
        exp_done           = c;
        c++;
        for (int k = 0; k < int'(RL) + 2; k++) begin
            exp_q[c].iter      = IW'(it);
            exp_q[c].converged = cv;
            c++;
        end
        frame_len = c;
        for (int i = int'(RL); i < c; i++) exp_q[i].out_valid = rd[i-int'(RL)];
        for (int i = exp_done + 1; i < MAXC; i++) st[i] = 1'b0;
        prev_conv = cv;
        prev_iter = IW'(it);
    endtask

    task automatic run_frame(input string name, input int rst_at);
        obs_t got;
        obs_done = -1; obs_ov = -1; obs_cnu = -1; obs_vnu = -1; obs_conv = -1; obs_iter = -1;
        for (int c = 0; c < frame_len; c++) begin
            start     = st[c];
            in_valid  = iv[c];
            syn_in    = sy[c];
            syn_valid = sv[c];
            rst       = (c == rst_at);
            #1;
            got = sample();
            check($sformatf("%s_c%0d", name, c), got, exp_q[c]);
            if (got.done && obs_done < 0) begin
                obs_done = c;
                obs_conv = int'(got.converged);
                obs_iter = int'(got.iter);
            end
            if (got.out_valid && obs_ov < 0) obs_ov = c;
            if (got.cnu && obs_cnu < 0) obs_cnu = c;
            if (got.vnu && obs_vnu < 0) obs_vnu = c;
            @(posedge clk);
            #1;
            if (c == rst_at) begin
                rst      = 1'b0;
                start    = 1'b0;
                in_valid = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    check($sformatf("%s_postrst%0d", name, k), sample(), '0);
                    if (done) obs_done = c + 1 + k;
                    @(posedge clk);
                    #1;
                end
                prev_conv = 1'b0;
                prev_iter = '0;
                break;
            end
        end
        start     = 1'b0;
        in_valid  = 1'b0;
        syn_valid = 1'b0;
        rst       = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; syn_in = '0; syn_valid = 1'b0;
        prev_conv = 1'b0;
        prev_iter = '0;
        @(posedge clk);
        #1;
        check("reset", sample(), '0);
        start = 1'b1;
        @(posedge clk);
        #1;
        check("reset_over_start", sample(), '0);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("idle", sample(), '0);

        clear_stim();
        build_frame();
        run_frame("noconv", -1);
        check_int("noconv_cnu_first", obs_cnu, 5);
        check_int("noconv_done", obs_done, 45);
        check_int("noconv_ov_first", obs_ov, 43);
        check_int("noconv_iter", obs_iter, 3);
        check_int("noconv_conv", obs_conv, 0);

        clear_stim();
        for (int i = 17; i < MAXC; i++) sy[i] = '0;
        build_frame();
        run_frame("early", -1);
        check_int("early_done", obs_done, 27);
        check_int("early_conv", obs_conv, 1);
        check_int("early_iter", obs_iter, 1);

        clear_stim();
        for (int i = 5; i <= 10; i++) sy[i] = '0;
        build_frame();
        run_frame("zero_first", -1);
        check_int("zero_first_vnu", obs_vnu, 11);

        clear_stim();
        iv[2] = 1'b0;
        iv[3] = 1'b0;
        build_frame();
        run_frame("stall", -1);
        check_int("stall_cnu_first", obs_cnu, 7);

        clear_stim();
        st[3]  = 1'b1;
        st[20] = 1'b1;
        build_frame();
        run_frame("busy_start", -1);
        check_int("busy_start_done", obs_done, 45);

        clear_stim();
        build_frame();
        run_frame("rst_mid", 13);
        check_int("rst_mid_no_done", obs_done, -1);
        clear_stim();
        build_frame();
        run_frame("after_rst", -1);
        check_int("after_rst_done", obs_done, 45);

        for (int f = 0; f < 16; f++) begin
            int conv_at;
            clear_stim();
            conv_at = int'($urandom_range(5, 60));
            for (int i = 1; i < MAXC; i++) begin
                iv[i] = (i < 20) ? ($urandom_range(0, 3) != 0) : 1'b1;
                sv[i] = ($urandom_range(0, 3) != 0);
                sy[i] = (i >= conv_at) ? '0 : SW'($urandom);
                st[i] = ($urandom_range(0, 7) == 0);
            end
            build_frame();
            run_frame($sformatf("rand%0d", f), -1);
            check_int($sformatf("rand%0d_done", f), obs_done, exp_done);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/ldpc_decode_sequencer.md
# ldpc_decode_sequencer

Sequences one LDPC decoder frame through its phases: intrinsic load, alternating check-node (CNU) and variable-node (VNU) sweeps, syndrome-based early termination, and hard-decision read-out. It sits above the PE-block array and drives the enable, phase and address lines that the array currently takes from top-level ports. It also collects the CNU parity bits to decide convergence.

## Interface
Parameters:
- L, 32: words per PE memory (sweep length).
- ADDR_WIDTH, 5: log2(L).
- K, 6: CNUs per layer; the syndrome is 3*K bits wide.
- ITER_WIDTH, 5: width of the iteration counter.
- MAX_ITER, 16: iteration cap, ≥1.
- CNU_LAT, 4: drain cycles after each sweep (shuffle→CNU→unshuffle pipeline).
- READ_LAT, 2: cycles from `read_add` to valid `dec_out_fin`.

Ports:
- clk  in  1  decoder clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- in_valid  in  1  intrinsic word present on the array's `int_in`.
- in_ready  out  1  high throughout LOAD.
- syn_in  in  3*K  CNU parity bits; 1 means unsatisfied.
- syn_valid  in  1  `syn_in` is meaningful this cycle.
- en  out  1  PE array enable; high in LOAD, CNU, VNU and READ.
- load_en  out  1  in_valid & in_ready.
- cnu_phase  out  1  high in CNU (sweep and drain).
- vnu_phase  out  1  high in VNU (sweep and drain).
- sweep_en  out  1  high on the L address cycles of CNU or VNU.
- load_add  out  ADDR_WIDTH  intrinsic write address.
- sweep_add  out  ADDR_WIDTH  CNU/VNU memory address.
- read_add  out  ADDR_WIDTH  hard-decision read address.
- out_valid  out  1  `dec_out_fin` is valid; `read_en` delayed by READ_LAT.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse at end of frame.
- converged  out  1  frame ended on a zero syndrome; held until the next start.
- iter_count  out  ITER_WIDTH  completed iterations; held until the next start.

## Operation
- States: IDLE, LOAD, CNU, VNU, READ, DONE.
- IDLE:
  - start=1 → LOAD.
  - On this transition, clear load_add, iter_count and converged.
- LOAD:
  - Each accepted word (load_en) increments load_add.
  - Cycles with in_valid=0 stall the state and the address.
  - After the L-th accept → CNU.
- CNU:
  - L sweep cycles, sweep_add 0..L-1, sweep_en=1.
  - Then CNU_LAT drain cycles with sweep_en=0 and sweep_add=0.
  - Syndrome accumulator: cleared on CNU entry. It ORs in syn_in on every CNU cycle with syn_valid=1, and on the last drain cycle it includes that cycle's syn_in.
  - At the end of drain, if accumulator==0 and iter_count≥1: set converged=1 and go to READ.
  - Otherwise → VNU.
  - The syndrome is not trusted before the first VNU, so iteration 0 never exits early.
- VNU:
  - Same L+CNU_LAT structure as CNU; syn_in is ignored.
  - At the end: iter_count+1. If the new value == MAX_ITER → READ, else → CNU.
- READ:
  - L cycles, read_add 0..L-1, read_en internal.
  - Then → DONE.
  - out_valid is read_en passed through a READ_LAT-stage shift register, so the last out_valid falls after DONE.
- DONE: done=1 for one cycle → IDLE.
- A start asserted while busy is ignored (not queued).
- Outputs are registered from the state and counters; in_ready and load_en are decoded combinationally from the state.
- Address counters are exactly ADDR_WIDTH bits. L is a power of two, so each counter wraps naturally to 0 when its phase ends.
- iter_count never exceeds MAX_ITER.

## Timing
- Reset: state=IDLE; every output, the address counters, the accumulator and the out_valid pipe are 0 on the cycle after rst is sampled high. A reset in any state aborts the frame with no done pulse.
- rst has priority over start in the same cycle.
- start sampled at cycle t:
  - LOAD begins at t+1 with load_add=0.
  - If in_valid stays high, the first CNU cycle is t+1+L.
- Each full iteration takes 2·(L+CNU_LAT) cycles.
- READ takes L cycles, DONE takes 1.
- out_valid for read_add=a appears READ_LAT cycles after that address.

## Test plan
With L=4, ADDR_WIDTH=2, CNU_LAT=2, READ_LAT=2, MAX_ITER=3, in_valid=1, start at cycle 0:
- **No convergence** (syn_in=1 throughout): LOAD at 1–4; CNU starts at 5, 17, 29; READ at 41–44; done at 45; iter_count=3; converged=0; out_valid at 43–46.
- **Early exit**: syn_in=0 from cycle 17 → the second CNU ends at 22, READ at 23–26, done at 27, iter_count=1, converged=1.
- **Zero syndrome in the first CNU** (cycles 5–10): there is no early exit and VNU starts at 11.
- **Load stall**: in_valid low on cycles 2–3 → load_add holds and CNU starts at 7.
- **Reset mid-sweep**: rst at cycle 13 (in VNU) → from 14, busy=0, en=0, all addresses 0, no done pulse. A new start then reruns the frame from LOAD.
- **start while busy**: start pulses at cycles 3 and 20 are ignored; the frame timing is identical to the no-convergence case.
